// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer
// Description : PC, run-state (IDLE/RUN/DONE) and performance counters for
//               the 9-bit-instruction core.
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer #(
   parameter int PC_W  = 10,
   parameter int OFF_W = 8,
   parameter int CNT_W = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Halt,
   input  logic              Stall,
   input  logic              AbsBranch,
   input  logic              RelBranch,
   input  logic              BranchFlag,
   input  logic              BranchInvert,
   input  logic              Zero,
   input  logic              Negative,
   input  logic [PC_W-1:0]   Target,
   input  logic [OFF_W-1:0]  Offset,
   output logic [PC_W-1:0]   PC,
   output logic              Running,
   output logic              Done,
   output logic [CNT_W-1:0]  CycleCount,
   output logic [CNT_W-1:0]  BranchCount
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
   localparam logic [PC_W-1:0]  c_pc_one  = PC_W'(1);

   state_t           r_state;
   logic             w_taken;
   logic [PC_W-1:0]  w_off_ext;
   logic [CNT_W-1:0] w_cycle_inc;
   logic [CNT_W-1:0] w_branch_inc;

   assign w_taken      = (BranchFlag ? Negative : Zero) ^ BranchInvert;
   assign w_off_ext    = PC_W'($signed(Offset));
   // Counters stick at all-ones rather than wrapping
   assign w_cycle_inc  = (CycleCount  == c_cnt_max) ? CycleCount  : CycleCount  + c_cnt_one;
   assign w_branch_inc = (BranchCount == c_cnt_max) ? BranchCount : BranchCount + c_cnt_one;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state     <= S_IDLE;
         PC          <= '0;
         Running     <= 1'b0;
         Done        <= 1'b0;
         CycleCount  <= '0;
         BranchCount <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               PC          <= '0;
               CycleCount  <= '0;
               BranchCount <= '0;
               if (Start) begin
                  r_state <= S_RUN;
                  Running <= 1'b1;
               end
            end
            S_RUN: begin
               CycleCount <= w_cycle_inc;
               if (Stall) begin
                  PC <= PC;
               end else if (Halt) begin
                  r_state <= S_DONE;
                  Running <= 1'b0;
                  Done    <= 1'b1;
               end else if (AbsBranch && w_taken) begin
                  PC          <= Target;
                  BranchCount <= w_branch_inc;
               end else if (RelBranch && w_taken) begin
                  PC          <= PC + w_off_ext;
                  BranchCount <= w_branch_inc;
               end else begin
                  PC <= PC + c_pc_one;
               end
            end
            S_DONE: begin
               // A restart clears the program state on the same edge
               if (Start) begin
                  r_state     <= S_RUN;
                  Running     <= 1'b1;
                  Done        <= 1'b0;
                  PC          <= '0;
                  CycleCount  <= '0;
                  BranchCount <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               Running <= 1'b0;
               Done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer
// Description : Directed and randomized checks of program_sequencer against
//               a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

   localparam int PC_W    = 10;
   localparam int OFF_W   = 8;
   localparam int CNT_W   = 8;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             Clk = 1'b0;
   logic             Reset, Start, Halt, Stall, AbsBranch, RelBranch;
   logic             BranchFlag, BranchInvert, Zero, Negative;
   logic [PC_W-1:0]  Target;
   logic [OFF_W-1:0] Offset;
   logic [PC_W-1:0]  PC;
   logic             Running, Done;
   logic [CNT_W-1:0] CycleCount, BranchCount;

   int compared   = 0;
   int mismatched = 0;

   // reference model: 0 = idle, 1 = run, 2 = done
   int m_state = 0;
   int m_pc    = 0;
   int m_cyc   = 0;
   int m_bc    = 0;

   program_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
      .AbsBranch(AbsBranch), .RelBranch(RelBranch), .BranchFlag(BranchFlag),
      .BranchInvert(BranchInvert), .Zero(Zero), .Negative(Negative),
      .Target(Target), .Offset(Offset), .PC(PC), .Running(Running),
      .Done(Done), .CycleCount(CycleCount), .BranchCount(BranchCount)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      bit taken;
      taken = (BranchFlag ? Negative : Zero) ^ BranchInvert;
      if (!Reset) begin
         m_state = 0; m_pc = 0; m_cyc = 0; m_bc = 0;
      end else if (m_state == 0) begin
         if (Start) m_state = 1;
      end else if (m_state == 1) begin
         if (m_cyc < CNT_MAX) m_cyc++;
         if (Stall) begin
         end else if (Halt) begin
            m_state = 2;
         end else if (AbsBranch && taken) begin
            m_pc = int'(Target);
            if (m_bc < CNT_MAX) m_bc++;
         end else if (RelBranch && taken) begin
            m_pc = (m_pc + int'($signed(Offset)) + PC_MOD) % PC_MOD;
            if (m_bc < CNT_MAX) m_bc++;
         end else begin
            m_pc = (m_pc + 1) % PC_MOD;
         end
      end else if (Start) begin
         m_state = 1; m_pc = 0; m_cyc = 0; m_bc = 0;
      end
   end

   task automatic quiet_inputs();
      Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
      AbsBranch = 1'b0; RelBranch = 1'b0; BranchFlag = 1'b0; BranchInvert = 1'b0;
      Zero = 1'b0; Negative = 1'b0; Target = '0; Offset = '0;
   endtask

   // one cycle of taken absolute branch, used to place the PC
   task automatic jump_to(input int addr);
      quiet_inputs();
      AbsBranch = 1'b1; Zero = 1'b1; Target = PC_W'(addr);
      @(negedge Clk);
      quiet_inputs();
   endtask

   task automatic test_reset();
      quiet_inputs();
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      compared++;
      if (PC !== 0 || Running !== 0 || Done !== 0 || CycleCount !== 0 || BranchCount !== 0) begin
         mismatched++;
         $display("FAIL reset: PC=%0d Run=%b Done=%b Cyc=%0d Br=%0d, required all 0",
                  PC, Running, Done, CycleCount, BranchCount);
      end
   endtask

   task automatic test_start();
      quiet_inputs();
      @(negedge Clk);
      compared++;
      if (Running !== 1'b0) begin
         mismatched++; $display("FAIL idle_no_start: Running=%b required 0", Running);
      end
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      compared++;
      if (Running !== 1'b1 || PC !== 0) begin
         mismatched++; $display("FAIL start: Running=%b PC=%0d required 1/0", Running, PC);
      end
      repeat (5) @(negedge Clk);
      compared++;
      if (PC !== 5 || CycleCount !== 5) begin
         mismatched++; $display("FAIL seq5: PC=%0d Cyc=%0d required 5/5", PC, CycleCount);
      end
   endtask

   task automatic test_rel_branch();
      int bc0;
      jump_to(20);
      bc0 = m_bc;
      RelBranch = 1'b1; Zero = 1'b1; Offset = 8'hF6;
      @(negedge Clk);
      compared++;
      if (PC !== 10 || int'(BranchCount) !== bc0 + 1) begin
         mismatched++;
         $display("FAIL rel_taken: PC=%0d Br=%0d required 10/%0d", PC, BranchCount, bc0 + 1);
      end
      jump_to(20);
      bc0 = m_bc;
      RelBranch = 1'b1; Zero = 1'b0; Offset = 8'hF6;
      @(negedge Clk);
      compared++;
      if (PC !== 21 || int'(BranchCount) !== bc0) begin
         mismatched++;
         $display("FAIL rel_not_taken: PC=%0d Br=%0d required 21/%0d", PC, BranchCount, bc0);
      end
   endtask

   task automatic test_abs_invert();
      for (int n = 0; n < 2; n++) begin
         jump_to(3);
         AbsBranch = 1'b1; RelBranch = 1'b1; BranchFlag = 1'b1; BranchInvert = 1'b1;
         Negative = n[0]; Target = 10'd700; Offset = 8'd50;
         @(negedge Clk);
         compared++;
         if (PC !== ((n == 0) ? 10'd700 : 10'd4)) begin
            mismatched++;
            $display("FAIL abs_invert neg=%0d: PC=%0d required %0d", n, PC, (n == 0) ? 700 : 4);
         end
      end
   endtask

   task automatic test_wrap();
      jump_to(1023);
      @(negedge Clk);
      compared++;
      if (PC !== 0) begin
         mismatched++; $display("FAIL wrap_inc: PC=%0d required 0", PC);
      end
      jump_to(2);
      RelBranch = 1'b1; Zero = 1'b1; Offset = 8'hFB;
      @(negedge Clk);
      compared++;
      if (PC !== 1021) begin
         mismatched++; $display("FAIL wrap_rel: PC=%0d required 1021", PC);
      end
   endtask

   task automatic test_stall_halt();
      int pc0, cyc0;
      quiet_inputs();
      pc0 = m_pc; cyc0 = m_cyc;
      Stall = 1'b1; Halt = 1'b1; AbsBranch = 1'b1; Zero = 1'b1; Target = 10'd99;
      repeat (3) @(negedge Clk);
      compared++;
      if (int'(PC) !== pc0 || Running !== 1'b1 || int'(CycleCount) !== cyc0 + 3) begin
         mismatched++;
         $display("FAIL stall_hold: PC=%0d Run=%b Cyc=%0d required %0d/1/%0d",
                  PC, Running, CycleCount, pc0, cyc0 + 3);
      end
      Stall = 1'b0;
      @(negedge Clk);
      compared++;
      if (Done !== 1'b1 || Running !== 1'b0 || int'(PC) !== pc0) begin
         mismatched++;
         $display("FAIL halt: Done=%b Run=%b PC=%0d required 1/0/%0d", Done, Running, PC, pc0);
      end
      quiet_inputs();
      repeat (2) @(negedge Clk);
      compared++;
      if (Done !== 1'b1 || int'(PC) !== pc0) begin
         mismatched++; $display("FAIL done_hold: Done=%b PC=%0d required 1/%0d", Done, PC, pc0);
      end
      Start = 1'b1;
      @(negedge Clk);
      compared++;
      if (PC !== 0 || CycleCount !== 0 || BranchCount !== 0 || Running !== 1'b1 || Done !== 1'b0) begin
         mismatched++;
         $display("FAIL restart: PC=%0d Cyc=%0d Br=%0d Run=%b Done=%b required 0/0/0/1/0",
                  PC, CycleCount, BranchCount, Running, Done);
      end
      repeat (2) @(negedge Clk);
      compared++;
      if (PC !== 2 || CycleCount !== 2 || Running !== 1'b1) begin
         mismatched++;
         $display("FAIL start_held: PC=%0d Cyc=%0d Run=%b required 2/2/1", PC, CycleCount, Running);
      end
      quiet_inputs();
   endtask

   task automatic test_saturation();
      quiet_inputs();
      repeat (CNT_MAX + 40) @(negedge Clk);
      compared++;
      if (int'(CycleCount) !== CNT_MAX || int'(PC) !== m_pc) begin
         mismatched++;
         $display("FAIL cyc_sat: Cyc=%0d PC=%0d required %0d/%0d", CycleCount, PC, CNT_MAX, m_pc);
      end
      for (int i = 0; i < CNT_MAX + 10; i++) jump_to(i % PC_MOD);
      compared++;
      if (int'(BranchCount) !== CNT_MAX) begin
         mismatched++; $display("FAIL br_sat: Br=%0d required %0d", BranchCount, CNT_MAX);
      end
   endtask

   task automatic test_reset_mid_run();
      jump_to(37);
      Reset = 1'b0; Start = 1'b1; Stall = 1'b1;
      @(negedge Clk);
      compared++;
      if (PC !== 0 || Running !== 0 || Done !== 0 || CycleCount !== 0 || BranchCount !== 0) begin
         mismatched++;
         $display("FAIL reset_mid_run: PC=%0d Run=%b Done=%b Cyc=%0d Br=%0d, required all 0",
                  PC, Running, Done, CycleCount, BranchCount);
      end
      quiet_inputs();
      @(negedge Clk);
      compared++;
      if (Running !== 1'b0 || PC !== 0) begin
         mismatched++; $display("FAIL post_reset_idle: Run=%b PC=%0d required 0/0", Running, PC);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         Reset        = ($urandom_range(0, 59) != 0);
         Start        = ($urandom_range(0, 3) == 0);
         Halt         = ($urandom_range(0, 24) == 0);
         Stall        = ($urandom_range(0, 3) == 0);
         AbsBranch    = ($urandom_range(0, 3) == 0);
         RelBranch    = ($urandom_range(0, 2) == 0);
         BranchFlag   = 1'($urandom);
         BranchInvert = 1'($urandom);
         Zero         = 1'($urandom);
         Negative     = 1'($urandom);
         Target       = PC_W'($urandom);
         Offset       = OFF_W'($urandom);
         @(negedge Clk);
         compared++;
         if (int'(PC) !== m_pc || Running !== (m_state == 1) || Done !== (m_state == 2) ||
             int'(CycleCount) !== m_cyc || int'(BranchCount) !== m_bc) begin
            mismatched++;
            $display("FAIL random[%0d]: PC=%0d Run=%b Done=%b Cyc=%0d Br=%0d required %0d/%b/%b/%0d/%0d",
                     i, PC, Running, Done, CycleCount, BranchCount,
                     m_pc, m_state == 1, m_state == 2, m_cyc, m_bc);
         end
      end
      quiet_inputs();
   endtask

   initial begin
      test_reset();
      test_start();
      test_rel_branch();
      test_abs_invert();
      test_wrap();
      test_stall_halt();
      test_saturation();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
# program_sequencer

Program-counter and run-state controller for the 9-bit-instruction core. Sits between the instruction decoder/ALU flag register and instruction memory. Owns:
- the PC and its next-address selection (sequential, relative branch, absolute branch);
- program start/stop sequencing (Start/Done handshake with the testbench);
- stall holding;
- cycle and taken-branch counters for performance reporting.

## Interface
Parameters:
- PC_W, 10, program counter width (instruction memory depth 2^PC_W)
- OFF_W, 8, width of signed relative branch offset
- CNT_W, 16, width of cycle and branch counters

Ports:
- Clk  input  1  core clock; all state updates on rising edge
- Reset  input  1  synchronous, active-low; reset taken on a rising edge of Clk while low
- Start  input  1  request to begin program execution from address 0
- Halt  input  1  current instruction is the terminating instruction (decoded externally)
- Stall  input  1  current instruction not complete this cycle; hold PC
- AbsBranch  input  1  current instruction is an absolute branch
- RelBranch  input  1  current instruction is a relative branch
- BranchFlag  input  1  flag to test: 0 = Zero, 1 = Negative
- BranchInvert  input  1  invert the tested flag
- Zero  input  1  registered ALU zero flag
- Negative  input  1  registered ALU negative flag
- Target  input  PC_W  absolute branch destination (register value)
- Offset  input  OFF_W  signed relative branch displacement
- PC  output  PC_W  current instruction address
- Running  output  1  high in RUN; gates RegWrite/MemWrite downstream
- Done  output  1  high in DONE
- CycleCount  output  CNT_W  RUN cycles since last start
- BranchCount  output  CNT_W  taken branches since last start

## Operation
- States: IDLE, RUN, DONE. Encoding is free. Running = (state==RUN). Done = (state==DONE).
- IDLE: PC, CycleCount and BranchCount held at 0. Start=1 -> RUN.
- RUN, each cycle, in priority order:
  1. Stall=1: PC holds. Halt and branch inputs ignored. CycleCount increments.
  2. Halt=1: -> DONE. PC holds. CycleCount increments. Branch inputs ignored.
  3. Otherwise compute taken = (BranchFlag ? Negative : Zero) ^ BranchInvert.
     - AbsBranch & taken: PC <= Target.
     - else RelBranch & taken: PC <= PC + sign_extend(Offset), modulo 2^PC_W.
     - else: PC <= PC + 1, modulo 2^PC_W (wraps from 2^PC_W-1 to 0).
     - AbsBranch has priority when both branch inputs are high.
     - BranchCount increments on a taken branch of either kind.
     - CycleCount increments.
- DONE: PC and counters hold. Start=1 -> RUN, with PC, CycleCount and BranchCount cleared to 0 on the same edge.
- Start is ignored in RUN.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Zero/Negative are sampled in the same cycle as the branch inputs; no internal flag storage.

## Timing
- Reset (Reset=0 at edge): state=IDLE, PC=0, Running=0, Done=0, CycleCount=0, BranchCount=0. Reset overrides every other input, including mid-RUN and mid-stall.
- All outputs are registered. No combinational path from inputs to outputs.
- Start sampled high in IDLE at edge N: Running=1 and PC=0 after edge N. The first instruction is fetched during cycle N+1.
- Branch decision at edge N: new PC visible after edge N. Single-cycle, no bubble.
- Halt at edge N (no stall): Done=1 and Running=0 after edge N. PC remains the halt instruction's address.
- Stall and Halt together: stall wins. Halt is taken on the first non-stalled edge.
- Start held continuously: one program run per DONE->RUN transition. The sequencer does not re-enter RUN from RUN.

## Test plan
- Reset/start: hold Reset=0 for 2 cycles -> all outputs 0. Release, pulse Start -> next cycle Running=1, PC=0. 5 cycles with no branch -> PC=5, CycleCount=5.
- Relative branch: PC=20, RelBranch=1, BranchFlag=0, BranchInvert=0, Zero=1, Offset=8'hF6 -> PC=10, BranchCount=1. Repeat with Zero=0 -> PC=21, BranchCount unchanged.
- Absolute branch and invert: PC=3, AbsBranch=1, RelBranch=1, BranchFlag=1, BranchInvert=1, Negative=0, Target=700 -> PC=700. Same with Negative=1 -> PC=4.
- Wrap: PC=1023, no branch -> PC=0. PC=2, RelBranch taken, Offset=-5 -> PC=1021.
- Stall/halt interaction: 3 cycles Stall=1 with Halt=1 -> PC held, Running=1, CycleCount +3. Drop Stall -> next cycle Done=1, PC unchanged. Pulse Start -> PC=0, counters 0, Running=1.
- Reset mid-run: at PC=37 with BranchCount=4, Reset=0 for one edge -> state IDLE, PC=0, counters 0. Start is ignored during that edge.
